// File: rtl/fruit_pkg.sv
// fruit_pkg: FSM states, level encodings and lane helpers shared by the fruit game blocks.
package fruit_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, PICK, SPAWN, HALT} sched_state_e;
    typedef enum logic [1:0] {LVL0, LVL1, LVL2, LVL3} level_e;

    function automatic logic [2:0] lane_mask(input logic [1:0] lvl);
        return lvl == LVL0 ? 3'b001 : lvl == LVL1 ? 3'b011 : 3'b111;
    endfunction

    function automatic logic [1:0] lane_next(input logic [1:0] i);
        return i == 2'd2 ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing every clock, reset to seed.
module lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= seed;
        else q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};

endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces fruit launches over three lanes by level; SPAWN_SCHEDULER_LFSR_EN
// selects a pseudo-random start lane instead of round-robin.
module spawn_scheduler
    import fruit_pkg::*;
#(
    parameter int unsigned INTERVAL0 = 48,
    parameter int unsigned INTERVAL1 = 32,
    parameter int unsigned INTERVAL2 = 20,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [1:0] level,
    input  logic       go,
    input  logic [2:0] done,
    output logic [2:0] spawn,
    output logic [2:0] active,
    output logic       halted
);

    if (LFSR_SEED == 8'h00) begin : g_seed_chk
        $error("LFSR_SEED must be nonzero");
    end

    sched_state_e state, state_n;
    logic [7:0] cnt, ival;
    logic [1:0] lvl, last, sel, start, i1, i2, pick;
    logic [2:0] cand, sel_hot;
    logic       load;

`ifdef SPAWN_SCHEDULER_LFSR_EN
    logic [7:0] q;
    lfsr8 u_lfsr (.clk, .rst_n, .seed(LFSR_SEED), .q);
    assign start = 2'(q % 8'd3);
`else
    assign start = lane_next(last);
`endif

    // level is sampled only when the counter loads; lvl holds it for the lane mask
    assign ival    = level == LVL0 ? 8'(INTERVAL0) : level == LVL1 ? 8'(INTERVAL1) : 8'(INTERVAL2);
    assign cand    = lane_mask(lvl) & ~active;
    assign i1      = lane_next(start);
    assign i2      = lane_next(i1);
    assign pick    = cand[start] ? start : cand[i1] ? i1 : i2;
    assign sel_hot = 3'b001 << sel;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        load    = 1'b0;
        if (go) state_n = HALT;
        else
            unique case (state)
                IDLE:  begin state_n = tick ? WAIT : IDLE; load = tick; end
                WAIT:  state_n = tick && cnt == 8'd1 ? PICK : WAIT;
                PICK:  state_n = |cand ? SPAWN : PICK;
                SPAWN: begin state_n = WAIT; load = 1'b1; end
                default: state_n = HALT;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt    <= 8'd0;
            spawn  <= 3'b000;
            active <= 3'b000;
            halted <= 1'b0;
            last   <= 2'd2;
            sel    <= 2'd0;
            lvl    <= 2'd0;
        end else if (go) begin
            spawn  <= 3'b000;
            active <= 3'b000;
            halted <= 1'b1;
        end else begin
            spawn  <= state == SPAWN ? sel_hot : 3'b000;
            active <= (active & ~done) | (state == SPAWN ? sel_hot : 3'b000);
            if (load) begin
                cnt <= ival;
                lvl <= level;
            end else if (state == WAIT && tick) cnt <= cnt - 8'd1;
            if (state == PICK) sel <= pick;
            if (state == SPAWN) last <= sel;
        end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 SHALL have parameter INTERVAL0, default 48: ticks between spawns at level 0.
REQ-002 SHALL have parameter INTERVAL1, default 32: ticks between spawns at level 1.
REQ-003 SHALL have parameter INTERVAL2, default 20: ticks between spawns at level 2 and level 3.
REQ-004 SHALL have parameter LFSR_SEED, default 8'hA5: LFSR reset value, nonzero.
REQ-005 SHALL have port clk  input  1: the single clock; all logic is posedge clk.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port tick  input  1: one-cycle frame pulse.
REQ-008 SHALL have port level  input  2: current game level from the scoring controller.
REQ-009 SHALL have port go  input  1: game over; level-sensitive.
REQ-010 SHALL have port done  input  3: per-lane pulse meaning the fruit was cut or missed.
REQ-011 SHALL have port spawn  output  3: one-hot, one-cycle launch pulse per lane.
REQ-012 SHALL have port active  output  3: lane currently holds a fruit.
REQ-013 SHALL have port halted  output  1: scheduler is stopped after game over.

Function
REQ-014 SHALL use FSM states IDLE, WAIT, PICK, SPAWN and HALT; all outputs SHALL be registered.
REQ-015 SHALL go IDLE->WAIT on the first tick and load the 8-bit interval counter with INTERVAL[level] on every entry to WAIT.
REQ-016 SHALL, in WAIT, decrement the counter on each tick; a tick with counter==1 SHALL go to PICK on the next edge.
REQ-017 SHALL define the enabled lanes by level: level 0 = lane 0; level 1 = lanes 0-1; level 2 or 3 = lanes 0-2.
REQ-018 SHALL compute candidates in PICK as enabled & ~active; with zero candidates it SHALL stay in PICK and retry every cycle, with no spawn.
REQ-019 SHALL select the first candidate searching upward with wrap from a start index, then go to SPAWN.
REQ-020 SHALL, in SPAWN, assert spawn[sel] for exactly one cycle, set active[sel] on the same edge, latch sel as last and return to WAIT.
REQ-021 SHALL clear active[i] on the edge after done[i]; done on an inactive lane SHALL be ignored.
REQ-022 SHALL produce spawn-to-next-spawn latency of interval ticks plus 2 clk cycles when lanes are free.
REQ-023 SHALL apply a level change only at the next counter load; lanes above the new level that are already active SHALL remain active until their done.
REQ-024 SHALL enter HALT from any state when go=1, force spawn=0, clear active and set halted=1; HALT SHALL be exited only by reset.
REQ-025 SHALL give go priority over tick, done and SPAWN in the same cycle.

Reset
REQ-026 SHALL set, while rst_n=0: state=IDLE, counter=0, spawn=0, active=0, halted=0, last=2, LFSR=LFSR_SEED.
REQ-027 SHALL abort any pending spawn on reset assertion mid-operation, with no glitch pulse after release.

Configuration
REQ-028 SHALL, with macro SPAWN_SCHEDULER_LFSR_EN defined, use an 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing every clk, with start index = LFSR[7:0] mod 3.
REQ-029 SHALL, without SPAWN_SCHEDULER_LFSR_EN, use round-robin with start index = (last+1) mod 3, and contain no LFSR logic.

Structure
REQ-030 SHALL place the FSM state enum, level encodings and the lane-enable mask function in shared package fruit_pkg.
REQ-031 SHALL place the LFSR in sub-module lfsr8 (clk, rst_n, seed, q[7:0]), instantiated only under SPAWN_SCHEDULER_LFSR_EN.

Verification
REQ-032 SHALL cover: INTERVAL0=4, level=0, tick every 3 clk -> spawn=3'b001 once; with no done, no further spawn and FSM held in PICK.
REQ-033 SHALL cover: round-robin, level=2, done issued one cycle after each spawn -> spawn sequence 001,010,100,001.
REQ-034 SHALL cover: level=1, active=2'b11 -> no spawn until done[1] -> next spawn=3'b010 exactly 2 clk after active[1] clears.
REQ-035 SHALL cover: go=1 in the same cycle as the SPAWN state -> spawn stays 0, active=0, halted=1, and no spawn over 100 further ticks.
REQ-036 SHALL cover: rst_n low mid-WAIT with active=3'b101 -> all outputs 0 asynchronously; after release, first spawn only after the first tick plus INTERVAL[level] ticks.
REQ-037 SHALL cover: with LFSR_EN, seed 8'hA5, level=2 over 300 spawns -> every lane is chosen at least 60 times and spawn is always one-hot.
